// File: rtl/rv32i_types_pkg.sv
// Shared types for the rv32i two-stage pipeline.
// Holds the special-instruction sequencer state encoding and its defaults.
package rv32i_types_pkg;

  localparam int unsigned FlushTimeoutDefault = 1024;
  localparam int unsigned SeqCntWDefault      = 16;

  typedef enum logic [2:0] {
    SeqRun,
    SeqDflush,
    SeqIclear,
    SeqRedirect,
    SeqWfiWait,
    SeqHaltDrain,
    SeqHalted
  } seq_state_t;

endpackage

// File: rtl/seq_timeout_counter.sv
// Cycle counter bounding a cache handshake.
// expire_o flags the last allowed cycle; FLUSH_TIMEOUT of 0 never expires.
module seq_timeout_counter
  import rv32i_types_pkg::*;
#(
  parameter int unsigned CNT_W         = SeqCntWDefault,
  parameter int unsigned FLUSH_TIMEOUT = FlushTimeoutDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LastCount =
      (FLUSH_TIMEOUT == 0) ? '0 : CNT_W'(FLUSH_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (FLUSH_TIMEOUT != 0) && (count_q == LastCount);

endmodule

// File: rtl/pipeline_sequencer.sv
// Multi-cycle sequencer for fence.i, wfi and halt in the two-stage pipeline.
// Stalls the pipe, drives cache flush/clear handshakes and the final redirect.
module pipeline_sequencer
  import rv32i_types_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = FlushTimeoutDefault,
  parameter int unsigned CNT_W         = SeqCntWDefault
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        ifence,
  input  logic        wfi,
  input  logic        halt,
  input  logic        exception,
  input  logic        irq_pending,
  input  logic        dmem_busy,
  input  logic        dcache_flush_done,
  input  logic        icache_clear_done,
  output logic        dcache_flush,
  output logic        icache_clear,
  output logic        stall,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wfi_active,
  output logic        halted,
  output logic        timeout_err
);

  seq_state_t  state_q, state_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic        timeout_err_q, timeout_err_d;
  logic        accept;
  logic        cnt_clear, cnt_enable, cnt_expire;

  // RST gates accept so the combinational stall cannot fire during reset.
  assign accept = instr_valid & ~exception & ~RST & (state_q == SeqRun);

  always_comb begin
    state_d       = state_q;
    saved_pc_d    = saved_pc_q;
    timeout_err_d = timeout_err_q;
    dcache_flush  = 1'b0;
    icache_clear  = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    wfi_active    = 1'b0;
    halted        = 1'b0;
    cnt_enable    = 1'b0;

    case (state_q)
      SeqRun: begin
        if (accept) begin
          if (halt) begin
            state_d = SeqHaltDrain;
            stall   = 1'b1;
          end else if (ifence) begin
            state_d    = SeqDflush;
            saved_pc_d = pc;
            stall      = 1'b1;
          end else if (wfi && !irq_pending) begin
            state_d = SeqWfiWait;
            stall   = 1'b1;
          end
        end
      end
      SeqDflush: begin
        dcache_flush = 1'b1;
        stall        = 1'b1;
        cnt_enable   = ~dcache_flush_done;
        if (dcache_flush_done || cnt_expire) begin
          state_d = SeqIclear;
          if (!dcache_flush_done) timeout_err_d = 1'b1;
        end
      end
      SeqIclear: begin
        icache_clear = 1'b1;
        stall        = 1'b1;
        cnt_enable   = ~icache_clear_done;
        if (icache_clear_done || cnt_expire) begin
          state_d = SeqRedirect;
          if (!icache_clear_done) timeout_err_d = 1'b1;
        end
      end
      SeqRedirect: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = saved_pc_q + 32'd4;
        state_d     = SeqRun;
      end
      SeqWfiWait: begin
        stall      = 1'b1;
        wfi_active = 1'b1;
        if (irq_pending) state_d = SeqRun;
      end
      SeqHaltDrain: begin
        stall = 1'b1;
        if (!dmem_busy) state_d = SeqHalted;
      end
      SeqHalted: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: state_d = SeqRun;
    endcase
  end

  // Any state change restarts the budget, which covers entry to both handshake states.
  assign cnt_clear = (state_d != state_q);

  seq_timeout_counter #(
    .CNT_W        (CNT_W),
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_timeout (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (cnt_clear),
    .enable_i(cnt_enable),
    .expire_o(cnt_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= SeqRun;
      saved_pc_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_pc_q    <= saved_pc_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Multi-cycle sequencer for the two-stage pipeline's special instructions: fence.i, wfi and halt, as flagged by the control unit decode outputs (ifence, wfi, halt).
- Stalls fetch and execute while a sequence runs.
- Drives the data-cache flush and instruction-cache clear handshakes.
- Issues the final squash and PC redirect.
- Sits between the decode/execute stage, the hazard unit and the cache controllers.

Parameters:
FLUSH_TIMEOUT, 1024, max cycles to wait for each cache handshake; 0 disables the timeout
CNT_W, 16, width of the timeout counter; FLUSH_TIMEOUT must be < 2^CNT_W

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
instr_valid  in  1  execute-stage instruction is valid and not otherwise stalled this cycle
pc  in  32  PC of the execute-stage instruction
ifence  in  1  decoded fence.i
wfi  in  1  decoded wfi
halt  in  1  decoded halt
exception  in  1  execute-stage instruction faults this cycle
irq_pending  in  1  (mip & mie) != 0, independent of mstatus.MIE
dmem_busy  in  1  data-memory transaction outstanding
dcache_flush_done  in  1  one-cycle pulse, D$ writeback complete
icache_clear_done  in  1  one-cycle pulse, I$ invalidation complete
dcache_flush  out  1  level request, held until done
icache_clear  out  1  level request, held until done
stall  out  1  freeze fetch and execute
flush  out  1  one-cycle squash of the fetch stage
redirect  out  1  one-cycle PC override
redirect_pc  out  32  target PC when redirect=1
wfi_active  out  1  core sleeping in wfi
halted  out  1  core halted
timeout_err  out  1  sticky flag: a cache handshake timed out

Behaviour:
- States: RUN, DFLUSH, ICLEAR, REDIRECT, WFI_WAIT, HALT_DRAIN, HALTED.
- Reset: state=RUN, counter=0, saved PC=0, timeout_err=0, all outputs 0. Reset mid-sequence abandons the sequence in one cycle with no final redirect; RST dominates all inputs.
- accept = instr_valid & !exception & state==RUN.
  - When accepted in RUN, priority is halt > ifence > wfi.
  - exception suppresses all starts.
  - These three inputs are ignored outside RUN.
- stall is combinational: asserted in the accept cycle T whenever a sequence starts (except wfi with irq_pending), and in every state except RUN and REDIRECT.
- fence.i:
  - T: latch pc. State goes to DFLUSH at T+1.
  - DFLUSH: dcache_flush=1. Done is sampled every cycle, including the first. On done, go to ICLEAR the next cycle.
  - ICLEAR: icache_clear=1. On done, go to REDIRECT.
  - REDIRECT (exactly 1 cycle): flush=1, redirect=1, stall=0, redirect_pc = saved_pc + 4 (mod 2^32; 0xFFFFFFFC wraps to 0). Then RUN.
  - Done pulses that arrive in any other state are ignored.
- Timeout (only when FLUSH_TIMEOUT != 0):
  - The counter clears on entry to DFLUSH and to ICLEAR, and increments every cycle without done.
  - When counter == FLUSH_TIMEOUT-1 with no done: set timeout_err and advance as if done arrived.
  - timeout_err clears only on RST.
- wfi:
  - If irq_pending=1 in T: no-op, stall=0, stay in RUN.
  - Otherwise go to WFI_WAIT: stall=1, wfi_active=1. When irq_pending=1, return to RUN the next cycle; stall and wfi_active drop in that RUN cycle. No redirect.
- halt:
  - HALT_DRAIN: stall=1, until dmem_busy=0 (checked from T+1). If dmem_busy is already 0 at T+1, the drain lasts one cycle.
  - HALTED: stall=1, halted=1, terminal until RST. irq_pending is ignored.

Decomposition:
- Add seq_state_t (the 7-state enum) and the FLUSH_TIMEOUT default constant to rv32i_types_pkg.
- One natural sub-module: seq_timeout_counter (clear, enable, expire output, parameterised on CNT_W/FLUSH_TIMEOUT). It is reused by the DFLUSH and ICLEAR states.

Test Plan:
- fence.i at pc=0x0000_0100; D$ done 3 cycles later, I$ done 2 cycles after that -> dcache_flush high for 3 cycles then icache_clear high for 2, then a 1-cycle redirect=1, flush=1, redirect_pc=0x104, stall high in every cycle before it.
- fence.i at pc=0xFFFF_FFFC with both done pulses in the first cycle of each state -> DFLUSH 1 cycle, ICLEAR 1 cycle, redirect_pc=0x0000_0000.
- FLUSH_TIMEOUT=4, D$ never acks -> dcache_flush high exactly 4 cycles, timeout_err=1 and stays 1, ICLEAR entered; RST clears timeout_err.
- wfi with irq_pending=0, irq raised after 10 cycles -> wfi_active and stall high 10 cycles, low the cycle after irq. Repeat with irq_pending=1 at issue -> stall never asserted.
- halt with dmem_busy high 5 more cycles -> HALT_DRAIN 5 cycles, then halted=1, stall=1 permanently; later ifence and irq are ignored.
- ifence with exception=1 -> no state change, dcache_flush=0. RST asserted in ICLEAR -> next cycle all outputs 0, state RUN, no redirect.
